// File: rtl/spi_pkg.sv
// spi_pkg: constants and state encoding shared by both ends of the SPI link.
package spi_pkg;
    localparam int SPI_DATA_WIDTH = 8;
    localparam logic SCK_IDLE  = 1'b1;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b1;
    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_e;
endpackage

// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI pins plus the receive valid/ack holding-register signals.
interface spi_slave_rx_if import spi_pkg::*; #(
    parameter int DW = SPI_DATA_WIDTH
);
    logic sck;
    logic cs;
    logic mosi;
    logic rx_ack;
    logic [DW-1:0] rx_data;
    logic rx_valid;
    logic overrun;
    logic frame_err;
    modport master (output sck, cs, mosi, rx_ack, input rx_data, rx_valid, overrun, frame_err);
    modport slave  (input sck, cs, mosi, rx_ack, output rx_data, rx_valid, overrun, frame_err);
endinterface

// File: rtl/spi_in_sync.sv
// spi_in_sync: synchroniser chain for one SPI pin, plus one extra register for edge detection.
module spi_in_sync import spi_pkg::*; #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = SCK_IDLE
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic cur_o,
    output logic prev_o
);
    logic [STAGES-1:0] sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign cur_o  = sync_q[STAGES-1];
    assign prev_o = prev_q;
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampling SPI slave receiver (sck idle high, cs active low, MSB first)
// presenting each completed frame through a valid/ack holding register.
module spi_slave_rx import spi_pkg::*; #(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset,
    spi_slave_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int SW = $clog2(SYNC_STAGES + 1);

    logic sck_cur, sck_prev, cs_cur, cs_prev, mosi_cur_unused, mosi_prev;
    logic ev, cs_rise, done;
    logic [CW-1:0] cnt_q, cnt_inc, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, rx_data_q;
    logic rx_valid_q, overrun_q, frame_err_q;
    logic [SW-1:0] settle_q;
    state_e state_q;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck (
        .clk, .reset, .d_i(bus.sck), .cur_o(sck_cur), .prev_o(sck_prev));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs (
        .clk, .reset, .d_i(bus.cs), .cur_o(cs_cur), .prev_o(cs_prev));
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_mosi (
        .clk, .reset, .d_i(bus.mosi), .cur_o(mosi_cur_unused), .prev_o(mosi_prev));

    // A bit ends when its sck-high phase ends, by sck falling or by cs rising.
    assign ev      = sck_prev & ~cs_prev & (~sck_cur | cs_cur);
    assign cs_rise = ~cs_prev & cs_cur;
    assign cnt_inc = cnt_q + 1'b1;
    assign done    = state_q == ACTIVE && ev && cnt_inc == CW'(DATA_WIDTH);
    assign cnt_d   = done ? '0 : ev ? cnt_inc : cnt_q;
    assign shift_d = ev ? {shift_q[DATA_WIDTH-2:0], mosi_prev} : shift_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_IDLE;
            settle_q    <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (done) begin
                rx_data_q  <= shift_d;
                rx_valid_q <= 1'b1;
                overrun_q  <= rx_valid_q & ~bus.rx_ack;
            end else if (bus.rx_ack) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                // The chains still hold their reset values until SYNC_STAGES edges have passed.
                WAIT_IDLE: begin
                    if (settle_q != SW'(SYNC_STAGES)) settle_q <= settle_q + 1'b1;
                    else if (cs_cur) state_q <= IDLE;
                end
                IDLE: begin
                    cnt_q <= '0;
                    if (!cs_cur) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        frame_err_q <= cnt_d != '0;
                        cnt_q       <= '0;
                        shift_q     <= '0;
                    end else begin
                        cnt_q   <= cnt_d;
                        shift_q <= shift_d;
                    end
                end
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule
